// File: rtl/typedef_pkg.sv
// Shared rename-stage sizing and the retire bus layout.
package typedef_pkg;
   localparam int NUM_PHY_REG  = 64;
   localparam int NUM_ARCH_REG = 32;
   localparam int PHY_WIDTH    = $clog2(NUM_PHY_REG);
   localparam int NUM_FREE     = NUM_PHY_REG - NUM_ARCH_REG;

   // Field names match the free_list retire ports one-for-one.
   typedef struct packed {
      logic                 retire_pr_valid;
      logic [4:0]           rd_arch;
      logic [PHY_WIDTH-1:0] rd_phy_old;
   } retire_bus_t;
endpackage

// File: rtl/fl_ram.sv
// Free-list storage: one asynchronous read port and one synchronous write port.
// Reset reloads every entry with INIT_BASE + index.
module fl_ram #(
   parameter int DEPTH     = 32,
   parameter int WIDTH     = 6,
   parameter int INIT_BASE = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= WIDTH'(INIT_BASE + i);
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/free_list.sv
// Physical-register free list with a speculative allocation head that a flush
// rewinds to the committed head. Grant is combinational; frees become visible next cycle.
module free_list
   import typedef_pkg::*;
#(
   parameter int NUM_PHY_REG  = typedef_pkg::NUM_PHY_REG,
   parameter int NUM_ARCH_REG = typedef_pkg::NUM_ARCH_REG,
   localparam int PHY_W       = $clog2(NUM_PHY_REG),
   localparam int NFREE       = NUM_PHY_REG - NUM_ARCH_REG,
   localparam int IDX_W       = $clog2(NFREE),
   localparam int PTR_W       = IDX_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_req,
   output logic             alloc_ready,
   output logic [PHY_W-1:0] alloc_phy,
   input  logic             retire_pr_valid,
   input  logic [4:0]       rd_arch,
   input  logic [PHY_W-1:0] rd_phy_old,
   output logic [PTR_W-1:0] free_count,
   output logic             overflow_err
);
   logic [PTR_W-1:0] spec_head_q, spec_head_d;
   logic [PTR_W-1:0] commit_head_q, commit_head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic             overflow_q, overflow_d;

   logic alloc_fire, retire_ok, list_full, free_drop, free_write;

   assign free_count  = tail_q - spec_head_q;
   assign alloc_ready = (tail_q != spec_head_q);
   assign list_full   = (free_count == PTR_W'(NFREE));

   assign alloc_fire  = alloc_req && alloc_ready && !flush;
   assign retire_ok   = retire_pr_valid && (rd_arch != 5'd0) && !flush;
   // A same-cycle grant vacates the slot the write lands in, so full is only fatal alone.
   assign free_drop   = retire_ok && list_full && !alloc_fire;
   assign free_write  = retire_ok && !free_drop;

   always_comb begin
      spec_head_d   = spec_head_q;
      commit_head_d = commit_head_q;
      tail_d        = tail_q;
      overflow_d    = overflow_q;
      if (flush) begin
         spec_head_d = commit_head_q;
      end else begin
         if (alloc_fire) begin
            spec_head_d = spec_head_q + PTR_W'(1);
         end
         if (free_write) begin
            tail_d        = tail_q + PTR_W'(1);
            commit_head_d = commit_head_q + PTR_W'(1);
         end
         if (free_drop) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_head_q   <= '0;
         commit_head_q <= '0;
         tail_q        <= PTR_W'(NFREE);
         overflow_q    <= 1'b0;
      end else begin
         spec_head_q   <= spec_head_d;
         commit_head_q <= commit_head_d;
         tail_q        <= tail_d;
         overflow_q    <= overflow_d;
      end
   end

   assign overflow_err = overflow_q;

   fl_ram #(
      .DEPTH     (NFREE),
      .WIDTH     (PHY_W),
      .INIT_BASE (NUM_ARCH_REG)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (free_write),
      .waddr_i (tail_q[IDX_W-1:0]),
      .wdata_i (rd_phy_old),
      .raddr_i (spec_head_q[IDX_W-1:0]),
      .rdata_o (alloc_phy)
   );
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: expected grants are queued as stimulus is planned
// and popped when the DUT grants; state outputs are checked against constants.
module tb_free_list;
   logic       clk = 1'b0;
   logic       rst, flush, alloc_req, alloc_ready;
   logic [5:0] alloc_phy, rd_phy_old, free_count;
   logic       retire_pr_valid, overflow_err;
   logic [4:0] rd_arch;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   free_list dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .alloc_req       (alloc_req),
      .alloc_ready     (alloc_ready),
      .alloc_phy       (alloc_phy),
      .retire_pr_valid (retire_pr_valid),
      .rd_arch         (rd_arch),
      .rd_phy_old      (rd_phy_old),
      .free_count      (free_count),
      .overflow_err    (overflow_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge; grants are compared before the rising edge.
   task automatic cyc(input logic a, input logic rv, input logic [4:0] ra,
                      input logic [5:0] rp, input logic f);
      @(negedge clk);
      rst = 1'b0; alloc_req = a; retire_pr_valid = rv; rd_arch = ra; rd_phy_old = rp; flush = f;
      #1;
      if (a && !f && exp_q.size() != 0) begin
         chk("grant_ready", alloc_ready, 1);
         chk("grant_phy", alloc_phy, exp_q.pop_front());
      end
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; alloc_req = 1'b0; retire_pr_valid = 1'b0; rd_arch = '0; rd_phy_old = '0; flush = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_free"}, free_count, 32);
      chk({tag, "_ready"}, alloc_ready, 1);
      chk({tag, "_phy"}, alloc_phy, 32);
      chk({tag, "_ovf"}, overflow_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; alloc_req = 1'b0; retire_pr_valid = 1'b0; rd_arch = '0; rd_phy_old = '0;
      do_reset();
      idle();
      chk_reset_state("reset");

      // Drain the whole list in order, then one request too many.
      for (int i = 0; i < 32; i++) exp_q.push_back(32'(32 + i));
      for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      idle();
      chk("drain_free", free_count, 0);
      chk("drain_ready", alloc_ready, 0);
      cyc(1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      chk("extra_req_ready", alloc_ready, 0);
      idle();
      chk("extra_req_free", free_count, 0);

      // Free into an empty list: visible only from the next cycle.
      cyc(1'b0, 1'b1, 5'd5, 6'd7, 1'b0);
      chk("empty_free_same_ready", alloc_ready, 0);
      idle();
      chk("empty_free_next_ready", alloc_ready, 1);
      chk("empty_free_next_phy", alloc_phy, 7);
      chk("empty_free_next_count", free_count, 1);

      // Flush rewinds to the committed head; the retired entry landed at the wrapped tail.
      do_reset();
      for (int i = 0; i < 3; i++) exp_q.push_back(32'(32 + i));
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      cyc(1'b0, 1'b1, 5'd1, 6'd5, 1'b0);
      cyc(1'b1, 1'b1, 5'd2, 6'd9, 1'b1);
      idle();
      chk("flush_free", free_count, 32);
      for (int i = 0; i < 3; i++) exp_q.push_back(32'(33 + i));
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      idle();
      chk("flush_after_alloc_free", free_count, 29);

      // Simultaneous allocate and free at free_count == 10.
      do_reset();
      for (int i = 0; i < 22; i++) exp_q.push_back(32'(32 + i));
      for (int i = 0; i < 22; i++) cyc(1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      idle();
      chk("ten_free", free_count, 10);
      exp_q.push_back(32'd54);
      cyc(1'b1, 1'b1, 5'd2, 6'd12, 1'b0);
      idle();
      chk("both_free", free_count, 10);
      for (int i = 55; i < 64; i++) exp_q.push_back(32'(i));
      exp_q.push_back(32'd12);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      idle();
      chk("both_drained", free_count, 0);

      // Retire to x0 is not a free.
      cyc(1'b0, 1'b1, 5'd0, 6'd9, 1'b0);
      idle();
      chk("x0_free", free_count, 0);
      chk("x0_ready", alloc_ready, 0);

      // Full list: allocate + free together is legal.
      do_reset();
      exp_q.push_back(32'd32);
      cyc(1'b1, 1'b1, 5'd4, 6'd20, 1'b0);
      idle();
      chk("full_both_ovf", overflow_err, 0);
      chk("full_both_free", free_count, 32);
      chk("full_both_phy", alloc_phy, 33);

      // Full list: lone free overflows and the error sticks.
      do_reset();
      cyc(1'b0, 1'b1, 5'd3, 6'd40, 1'b0);
      idle();
      chk("ovf_set", overflow_err, 1);
      chk("ovf_free", free_count, 32);
      chk("ovf_phy", alloc_phy, 32);
      exp_q.push_back(32'd32);
      cyc(1'b1, 1'b0, 5'd0, 6'd0, 1'b0);
      idle();
      idle();
      chk("ovf_sticky", overflow_err, 1);
      chk("ovf_sticky_free", free_count, 31);

      // Reset wins over concurrent alloc and retire.
      @(negedge clk);
      rst = 1'b1; alloc_req = 1'b1; retire_pr_valid = 1'b1; rd_arch = 5'd6; rd_phy_old = 6'd3; flush = 1'b0;
      @(negedge clk);
      rst = 1'b0; alloc_req = 1'b0; retire_pr_valid = 1'b0; rd_arch = '0; rd_phy_old = '0;
      #1;
      chk_reset_state("midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
